// File: rtl/sm_dm_arbiter_pkg.sv
// Shared types and defaults for the two-master data-memory arbiter.
package sm_dm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arbState_e;

  localparam int unsigned TIMEOUT_DEFAULT       = 256;
  localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/sm_rr_pick2.sv
// Combinational two-way round-robin pick; the owner pointer lives in the parent.
module sm_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o
);

  // On contention the master that did not own the slave last time wins.
  always_comb begin
    winner_o = 1'b0;
    if (req_i == 2'b11) begin
      winner_o = ~last_i;
    end else begin
      winner_o = req_i[1];
    end
  end

endmodule

// File: rtl/sm_dm_arbiter.sv
// Shares the single data-memory port between the CPU core (m0) and a second
// bus master (m1); round-robin, transaction-locked, with an optional watchdog.
module sm_dm_arbiter
  import sm_dm_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT       = TIMEOUT_DEFAULT,
  parameter logic [31:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wd,
  input  logic        m0_valid,
  output logic        m0_ready,
  output logic [31:0] m0_rd,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wd,
  input  logic        m1_valid,
  output logic        m1_ready,
  output logic [31:0] m1_rd,
  output logic [31:0] s_addr,
  output logic        s_we,
  output logic [31:0] s_wd,
  output logic        s_valid,
  input  logic        s_ready,
  input  logic [31:0] s_rd,
  output logic [1:0]  grant,
  output logic        timeout
);

  arbState_e state_q, state_d;
  logic      lastOwner_q, lastOwner_d;
  logic      pickWinner;
  logic      ownerValid;
  logic      ownerDone;
  logic      wdFire;

  sm_rr_pick2 uPick (
    .req_i    ({m1_valid, m0_valid}),
    .last_i   (lastOwner_q),
    .winner_o (pickWinner)
  );

  // Route the owning master onto the slave port; idle drives zeros.
  always_comb begin
    s_addr     = '0;
    s_we       = 1'b0;
    s_wd       = '0;
    s_valid    = 1'b0;
    grant      = 2'b00;
    ownerValid = 1'b0;
    case (state_q)
      BUSY0: begin
        s_addr     = m0_addr;
        s_we       = m0_we;
        s_wd       = m0_wd;
        s_valid    = m0_valid;
        grant      = 2'b01;
        ownerValid = m0_valid;
      end
      BUSY1: begin
        s_addr     = m1_addr;
        s_we       = m1_we;
        s_wd       = m1_wd;
        s_valid    = m1_valid;
        grant      = 2'b10;
        ownerValid = m1_valid;
      end
      default: ;
    endcase
  end

  // Watchdog counter clears while idle so every grant starts from zero.
  if (TIMEOUT > 0) begin : gWatchdog
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
        cnt_d = '0;
      end else if (!s_ready) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign wdFire = ownerValid & ~s_ready & (cnt_q == CW'(TIMEOUT - 1));
  end else begin : gNoWatchdog
    assign wdFire = 1'b0;
  end

  assign ownerDone = ownerValid & (s_ready | wdFire);
  assign m0_ready  = (state_q == BUSY0) & ownerDone;
  assign m1_ready  = (state_q == BUSY1) & ownerDone;
  assign timeout   = wdFire;
  assign m0_rd     = ((state_q == BUSY0) && wdFire) ? TIMEOUT_RDATA : s_rd;
  assign m1_rd     = ((state_q == BUSY1) && wdFire) ? TIMEOUT_RDATA : s_rd;

  // Every transaction ends in IDLE, giving the mandatory bubble cycle.
  always_comb begin
    state_d     = state_q;
    lastOwner_d = lastOwner_q;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d     = pickWinner ? BUSY1 : BUSY0;
          lastOwner_d = pickWinner;
        end
      end
      BUSY0, BUSY1: begin
        if (!ownerValid || ownerDone) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastOwner_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      lastOwner_q <= lastOwner_d;
    end
  end

endmodule

// File: tb/tb_sm_dm_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model of the arbiter.
module tb_sm_dm_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] TRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m0_addr = '0, m0_wd = '0, m1_addr = '0, m1_wd = '0;
  logic        m0_we = 1'b0, m0_valid = 1'b0, m1_we = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready, s_we, s_valid, timeout;
  logic [31:0] m0_rd, m1_rd, s_addr, s_wd;
  logic        s_ready = 1'b0;
  logic [31:0] s_rd = '0;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the port, who owned it last, how long it waited.
  int owner = -1;
  int lastOwner = 1;
  int waitCnt = 0;
  logic [1:0] lastReady = 2'b00;
  int done0 = 0, done1 = 0, timeouts = 0;

  sm_dm_arbiter #(.TIMEOUT(TO), .TIMEOUT_RDATA(TRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_we(m0_we), .m0_wd(m0_wd), .m0_valid(m0_valid),
    .m0_ready(m0_ready), .m0_rd(m0_rd),
    .m1_addr(m1_addr), .m1_we(m1_we), .m1_wd(m1_wd), .m1_valid(m1_valid),
    .m1_ready(m1_ready), .m1_rd(m1_rd),
    .s_addr(s_addr), .s_we(s_we), .s_wd(s_wd), .s_valid(s_valid),
    .s_ready(s_ready), .s_rd(s_rd),
    .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    owner     = -1;
    lastOwner = 1;
    waitCnt   = 0;
  endtask

  // Called at a negedge with inputs set; checks this cycle and advances the model.
  task automatic applyStimulus();
    logic        vIn [2];
    logic [31:0] aIn [2];
    logic [31:0] wIn [2];
    logic        weIn [2];
    logic [31:0] eRd [2];
    logic [31:0] eAddr, eWd;
    logic        eWe, eValid, eTo;
    logic [1:0]  eGrant, eReady;
    vIn[0] = m0_valid; aIn[0] = m0_addr; wIn[0] = m0_wd; weIn[0] = m0_we;
    vIn[1] = m1_valid; aIn[1] = m1_addr; wIn[1] = m1_wd; weIn[1] = m1_we;
    eAddr = '0; eWd = '0; eWe = 1'b0; eValid = 1'b0; eTo = 1'b0;
    eGrant = 2'b00; eReady = 2'b00;
    eRd[0] = s_rd; eRd[1] = s_rd;
    if (rst_n && owner >= 0) begin
      eGrant = 2'(1 << owner);
      eValid = vIn[owner];
      eAddr  = aIn[owner];
      eWd    = wIn[owner];
      eWe    = weIn[owner];
      if (vIn[owner]) begin
        if (s_ready) begin
          eReady[owner] = 1'b1;
        end else if (waitCnt == TO - 1) begin
          eReady[owner] = 1'b1;
          eTo = 1'b1;
          eRd[owner] = TRD;
        end
      end
    end
    #2;
    checkOutput("grant", 32'(grant), 32'(eGrant));
    checkOutput("s_valid", 32'(s_valid), 32'(eValid));
    checkOutput("s_addr", s_addr, eAddr);
    checkOutput("s_we", 32'(s_we), 32'(eWe));
    checkOutput("s_wd", s_wd, eWd);
    checkOutput("m0_ready", 32'(m0_ready), 32'(eReady[0]));
    checkOutput("m1_ready", 32'(m1_ready), 32'(eReady[1]));
    checkOutput("m0_rd", m0_rd, eRd[0]);
    checkOutput("m1_rd", m1_rd, eRd[1]);
    checkOutput("timeout", 32'(timeout), 32'(eTo));
    lastReady = eReady;
    done0 += int'(eReady[0]);
    done1 += int'(eReady[1]);
    timeouts += int'(eTo);
    @(posedge clk);
    if (!rst_n) begin
      resetModel();
    end else if (owner < 0) begin
      if (vIn[0] && vIn[1]) owner = 1 - lastOwner;
      else if (vIn[0]) owner = 0;
      else if (vIn[1]) owner = 1;
      if (owner >= 0) begin
        lastOwner = owner;
        waitCnt = 0;
      end
    end else if (!vIn[owner] || eReady[owner]) begin
      owner = -1;
    end else begin
      waitCnt++;
    end
    @(negedge clk);
  endtask

  task automatic setMaster(input int i, input logic v, input logic [31:0] a,
                           input logic we, input logic [31:0] wd);
    if (i == 0) begin
      m0_valid = v; m0_addr = a; m0_we = we; m0_wd = wd;
    end else begin
      m1_valid = v; m1_addr = a; m1_we = we; m1_wd = wd;
    end
  endtask

  initial begin
    logic pend [2];
    int   stall;
    pend[0] = 1'b0; pend[1] = 1'b0; stall = 0;

    @(negedge clk);
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;

    // Single m0 write, slave ready immediately.
    setMaster(0, 1'b1, 32'h0000_0040, 1'b1, 32'h1234_5678);
    s_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("singleDone", 32'(lastReady), 32'h1);
    m0_valid = 1'b0;
    applyStimulus();

    // Contention: four reads each, slave ready after one wait cycle.
    done0 = 0; done1 = 0;
    m0_we = 1'b0; m1_we = 1'b0; m0_addr = 32'h100; m1_addr = 32'h200;
    for (int c = 0; c < 80; c++) begin
      m0_valid = (done0 < 4);
      m1_valid = (done1 < 4);
      s_ready  = (owner >= 0) && (waitCnt >= 1);
      s_rd     = $urandom;
      if (!m0_valid && !m1_valid && owner < 0) break;
      applyStimulus();
    end
    checkOutput("m0Done", 32'(done0), 32'd4);
    checkOutput("m1Done", 32'(done1), 32'd4);
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

    // m1 read with five wait states while m0 is held off.
    done1 = 0;
    setMaster(1, 1'b1, 32'h300, 1'b0, 32'h0);
    s_rd = 32'hCAFE_0001;
    applyStimulus();
    m0_valid = 1'b1;
    for (int c = 0; c < 5; c++) applyStimulus();
    s_ready = 1'b1;
    applyStimulus();
    checkOutput("waitDone", 32'(done1), 32'd1);
    m1_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    m0_valid = 1'b0; s_ready = 1'b0;
    applyStimulus();

    // Watchdog: slave never answers an m0 read.
    timeouts = 0;
    setMaster(0, 1'b1, 32'h400, 1'b0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      applyStimulus();
      if (lastReady[0]) m0_valid = 1'b0;
    end
    checkOutput("toCount", 32'(timeouts), 32'd1);

    // Slave answers exactly on the last allowed cycle: normal completion.
    m0_valid = 1'b1;
    applyStimulus();
    for (int c = 0; c < TO - 1; c++) applyStimulus();
    s_ready = 1'b1;
    applyStimulus();
    checkOutput("lateReady", 32'(lastReady), 32'h1);
    checkOutput("lateNoTo", 32'(timeouts), 32'd1);
    m0_valid = 1'b0; s_ready = 1'b0;
    applyStimulus();

    // Owner abort during BUSY1.
    m1_valid = 1'b1;
    applyStimulus();
    applyStimulus();
    m1_valid = 1'b0;
    applyStimulus();
    applyStimulus();

    // Asynchronous reset mid-BUSY0, then m0 wins the first contention.
    m0_valid = 1'b1;
    applyStimulus();
    applyStimulus();
    rst_n = 1'b0;
    #1;
    checkOutput("rstGrant", 32'(grant), 32'h0);
    checkOutput("rstValid", 32'(s_valid), 32'h0);
    resetModel();
    @(negedge clk);
    m1_valid = 1'b1;
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rrAfterRst", 32'(grant), 32'h1);
    m0_valid = 1'b0; m1_valid = 1'b0;
    applyStimulus();
    applyStimulus();

    // Random traffic with occasional aborts and long slave stalls.
    lastReady = 2'b00;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && !lastReady[i]) begin
          if ($urandom_range(39) == 0) begin
            setMaster(i, 1'b0, 32'h0, 1'b0, 32'h0);
            pend[i] = 1'b0;
          end
        end else if ($urandom_range(1) == 1) begin
          setMaster(i, 1'b1, $urandom, 1'($urandom_range(1)), $urandom);
          pend[i] = 1'b1;
        end else begin
          setMaster(i, 1'b0, 32'h0, 1'b0, 32'h0);
          pend[i] = 1'b0;
        end
      end
      if (stall > 0) begin
        s_ready = 1'b0;
        stall--;
      end else begin
        s_ready = ($urandom_range(2) == 0);
        if ($urandom_range(49) == 0) stall = 12;
      end
      s_rd = $urandom;
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
